atmos_light_ctrl: RTL and testbench

Frame-level controller that produces the atmospheric-light value A consumed by the transmission-map stage.
- Observes the dark-channel pixel stream and tracks the per-frame maximum.
- At each frame end, updates A through a clamp and a first-order IIR smoother.
- Holds A constant for the whole next frame, so the downstream divider never sees A change mid-frame and never sees A below A_MIN (this guarantees no divide-by-zero).
- Supports a manual override of A.

---
 rtl/atmos_light_ctrl_pkg.sv | 25 ++
 rtl/atmos_light_ctrl_if.sv | 12 +
 rtl/atmos_light_ctrl_sync_edge_det.sv | 27 ++
 rtl/atmos_light_ctrl.sv | 154 +++++++++++++++
 tb/tb_atmos_light_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/atmos_light_ctrl_pkg.sv
// Shared types and defaults for the atmospheric-light controller and its sibling
// frame-level blocks.
package atmos_light_ctrl_pkg;

    localparam int PIX_W = 8;

    localparam logic [PIX_W-1:0] A_INIT_DEF       = 8'd255;
    localparam logic [PIX_W-1:0] A_MIN_DEF        = 8'd100;
    localparam int               SMOOTH_SHIFT_DEF = 2;
    localparam int               PIX_CNT_W_DEF    = 22;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_CALC  = 2'd2,
        ST_APPLY = 2'd3
    } state_e;

    function automatic pix_t pix_max(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/atmos_light_ctrl_if.sv
// Dark-channel pixel stream: frame/line/pixel qualifiers plus pixel data.
interface atmos_light_ctrl_if;

    logic                      dark_vsync;
    logic                      dark_href;
    logic                      dark_clken;
    atmos_light_ctrl_pkg::pix_t dark_img;

    modport master (output dark_vsync, dark_href, dark_clken, dark_img);
    modport slave  (input  dark_vsync, dark_href, dark_clken, dark_img);

endinterface

// File: rtl/atmos_light_ctrl_sync_edge_det.sv
// Registered rise/fall detector; RST_LVL chooses what the input is assumed to be
// at reset so a level already present at reset release produces no edge.
module atmos_light_ctrl_sync_edge_det #(
    parameter logic RST_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;
    logic d_d;

    always_comb d_d = d;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= RST_LVL;
        else        d_q <= d_d;
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/atmos_light_ctrl.sv
// Tracks the per-frame dark-channel maximum and, at each frame end, updates the
// atmospheric light A through a clamp and first-order IIR; A is frozen during frames.
module atmos_light_ctrl
    import atmos_light_ctrl_pkg::*;
#(
    parameter pix_t A_INIT       = A_INIT_DEF,
    parameter pix_t A_MIN        = A_MIN_DEF,
    parameter int   SMOOTH_SHIFT = SMOOTH_SHIFT_DEF,
    parameter int   PIX_CNT_W    = PIX_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    atmos_light_ctrl_if.slave   dark,
    input  logic                cfg_a_manual_en,
    input  pix_t                cfg_a_manual,
    output pix_t                A_value,
    output logic                a_valid,
    output logic                a_update,
    output pix_t                frame_max,
    output logic [15:0]         frame_cnt
);

    logic rise;
    logic fall;
    logic pix_ok;

    state_e               state_q, state_d;
    pix_t                 cur_max_q, cur_max_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    pix_t                 max_l_q, max_l_d;
    pix_t                 nxt_q, nxt_d;
    pix_t                 a_value_q, a_value_d;
    logic                 a_valid_q, a_valid_d;
    logic                 a_update_q, a_update_d;
    pix_t                 frame_max_q, frame_max_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;

    pix_t              src;
    pix_t              target;
    pix_t              smooth_c;
    logic signed [8:0] diff;
    logic signed [8:0] step;
    logic signed [8:0] smooth;

    // Reset level 1: a frame already in progress at reset release is ignored.
    atmos_light_ctrl_sync_edge_det #(.RST_LVL(1'b1)) u_vsync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dark.dark_vsync),
        .rise  (rise),
        .fall  (fall)
    );

    assign pix_ok = dark.dark_vsync & dark.dark_href & dark.dark_clken;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        cur_max_d = cur_max_q;
        pix_cnt_d = pix_cnt_q;
        if (rise) begin
            cur_max_d = pix_ok ? dark.dark_img : '0;
            pix_cnt_d = pix_ok ? PIX_CNT_W'(1) : '0;
        end else if (pix_ok) begin
            cur_max_d = pix_max(cur_max_q, dark.dark_img);
            if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (rise) state_d = ST_ACCUM;
            ST_ACCUM: if (fall) state_d = (pix_cnt_q != '0) ? ST_CALC : ST_IDLE;
            ST_CALC:  state_d = ST_APPLY;
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Smoother: 9-bit signed step, arithmetic shift floors toward -inf.
    always_comb begin
        src      = cfg_a_manual_en ? cfg_a_manual : max_l_q;
        target   = pix_max(src, A_MIN);
        diff     = $signed({1'b0, target}) - $signed({1'b0, a_value_q});
        step     = diff >>> SMOOTH_SHIFT;
        smooth   = $signed({1'b0, a_value_q}) + step;
        smooth_c = (smooth < $signed({1'b0, A_MIN})) ? A_MIN : smooth[7:0];
    end

    always_comb begin
        frame_max_d = frame_max_q;
        frame_cnt_d = frame_cnt_q;
        max_l_d     = max_l_q;
        nxt_d       = nxt_q;
        a_value_d   = a_value_q;
        a_valid_d   = a_valid_q;
        a_update_d  = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (fall) begin
                    frame_max_d = cur_max_q;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    max_l_d     = cur_max_q;
                end
            end
            ST_CALC: begin
                if (!a_valid_q || cfg_a_manual_en || (SMOOTH_SHIFT == 0)) nxt_d = target;
                else                                                     nxt_d = smooth_c;
            end
            ST_APPLY: begin
                a_value_d  = nxt_q;
                a_valid_d  = 1'b1;
                a_update_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_max_q   <= '0;
            pix_cnt_q   <= '0;
            max_l_q     <= '0;
            nxt_q       <= '0;
            a_value_q   <= A_INIT;
            a_valid_q   <= 1'b0;
            a_update_q  <= 1'b0;
            frame_max_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            cur_max_q   <= cur_max_d;
            pix_cnt_q   <= pix_cnt_d;
            max_l_q     <= max_l_d;
            nxt_q       <= nxt_d;
            a_value_q   <= a_value_d;
            a_valid_q   <= a_valid_d;
            a_update_q  <= a_update_d;
            frame_max_q <= frame_max_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign A_value   = a_value_q;
    assign a_valid   = a_valid_q;
    assign a_update  = a_update_q;
    assign frame_max = frame_max_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_atmos_light_ctrl.sv
// Directed bench for atmos_light_ctrl with default parameters (A_INIT 255, A_MIN 100, k 2).
module tb_atmos_light_ctrl;
    import atmos_light_ctrl_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_a_manual_en;
    pix_t        cfg_a_manual;
    pix_t        A_value;
    logic        a_valid;
    logic        a_update;
    pix_t        frame_max;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    atmos_light_ctrl_if dif ();

    atmos_light_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dark            (dif),
        .cfg_a_manual_en (cfg_a_manual_en),
        .cfg_a_manual    (cfg_a_manual),
        .A_value         (A_value),
        .a_valid         (a_valid),
        .a_update        (a_update),
        .frame_max       (frame_max),
        .frame_cnt       (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input bit seed, input pix_t seed_val);
        dif.dark_vsync = 1'b1;
        dif.dark_href  = seed;
        dif.dark_clken = seed;
        dif.dark_img   = seed ? seed_val : 8'd0;
        tick(1);
        dif.dark_href  = 1'b0;
        dif.dark_clken = 1'b0;
        dif.dark_img   = 8'd0;
    endtask

    // n valid pixels whose maximum is maxv, with ignored strobes of 255 mixed in.
    task automatic pixels(input string tag, input int n, input pix_t maxv, input pix_t exp_a);
        for (int i = 0; i < n; i++) begin
            if (i % 8 == 7) begin
                dif.dark_href  = 1'b1;
                dif.dark_clken = 1'b0;
                dif.dark_img   = 8'd255;
                tick(1);
            end
            dif.dark_href  = 1'b1;
            dif.dark_clken = 1'b1;
            dif.dark_img   = (i == n / 2) ? maxv : pix_t'(i % int'(maxv));
            tick(1);
        end
        dif.dark_href  = 1'b0;
        dif.dark_clken = 1'b1;
        dif.dark_img   = 8'd255;
        tick(1);
        dif.dark_clken = 1'b0;
        dif.dark_img   = 8'd0;
        check({tag, "_hold_A"}, A_value, exp_a);
    endtask

    task automatic end_frame(input string tag, input bit exp_upd, input pix_t exp_a,
                             input int exp_cnt, input pix_t exp_fmax, input bit exp_valid);
        dif.dark_vsync = 1'b0;
        tick(1);
        check({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
        check({tag, "_frame_max"}, frame_max, exp_fmax);
        check({tag, "_upd_k"}, a_update, 0);
        tick(1);
        check({tag, "_upd_k1"}, a_update, 0);
        tick(1);
        check({tag, "_upd_k2"}, a_update, exp_upd);
        check({tag, "_A"}, A_value, exp_a);
        check({tag, "_valid"}, a_valid, exp_valid);
        tick(1);
        check({tag, "_upd_off"}, a_update, 0);
    endtask

    initial begin
        dif.dark_vsync  = 1'b0;
        dif.dark_href   = 1'b0;
        dif.dark_clken  = 1'b0;
        dif.dark_img    = 8'd0;
        cfg_a_manual_en = 1'b0;
        cfg_a_manual    = 8'd0;
        tick(2);
        check("rst_A", A_value, 255);
        check("rst_valid", a_valid, 0);
        check("rst_upd", a_update, 0);
        check("rst_fmax", frame_max, 0);
        check("rst_fcnt", frame_cnt, 0);
        rst_n = 1'b1;
        tick(2);

        // First update is applied directly.
        start_frame(1'b0, 8'd0);
        pixels("f1", 64, 8'd200, 8'd255);
        end_frame("f1", 1'b1, 8'd200, 1, 8'd200, 1'b1);

        // 200 + (-80 >>> 2) = 180.
        start_frame(1'b0, 8'd0);
        pixels("f2", 40, 8'd120, 8'd200);
        end_frame("f2", 1'b1, 8'd180, 2, 8'd120, 1'b1);

        // Max 60 is seeded on the rise cycle; target clamps to 100 -> 160.
        start_frame(1'b1, 8'd60);
        pixels("f3", 30, 8'd40, 8'd180);
        end_frame("f3", 1'b1, 8'd160, 3, 8'd60, 1'b1);

        // Manual 200 bypasses smoothing.
        cfg_a_manual_en = 1'b1;
        cfg_a_manual    = 8'd200;
        start_frame(1'b0, 8'd0);
        pixels("f4", 20, 8'd90, 8'd160);
        end_frame("f4", 1'b1, 8'd200, 4, 8'd90, 1'b1);

        // Diff 3 >>> 2 = 0: A unchanged yet the pulse still fires.
        cfg_a_manual_en = 1'b0;
        start_frame(1'b0, 8'd0);
        pixels("f5", 50, 8'd203, 8'd200);
        end_frame("f5", 1'b1, 8'd200, 5, 8'd203, 1'b1);

        // Empty frame: href never high.
        start_frame(1'b0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            dif.dark_clken = 1'b1;
            dif.dark_img   = 8'd255;
            tick(1);
        end
        dif.dark_clken = 1'b0;
        end_frame("f6", 1'b0, 8'd200, 6, 8'd0, 1'b1);

        // Manual 50 switched on mid-frame: A held, then clamped to 100.
        start_frame(1'b0, 8'd0);
        pixels("f7a", 20, 8'd180, 8'd200);
        cfg_a_manual_en = 1'b1;
        cfg_a_manual    = 8'd50;
        pixels("f7b", 20, 8'd150, 8'd200);
        end_frame("f7", 1'b1, 8'd100, 7, 8'd180, 1'b1);

        cfg_a_manual = 8'd230;
        start_frame(1'b0, 8'd0);
        pixels("f8", 20, 8'd80, 8'd100);
        end_frame("f8", 1'b1, 8'd230, 8, 8'd80, 1'b1);
        cfg_a_manual_en = 1'b0;

        // Reset mid-frame, released while vsync stays high.
        start_frame(1'b0, 8'd0);
        pixels("f9a", 10, 8'd250, 8'd230);
        rst_n = 1'b0;
        #1;
        check("mrst_A", A_value, 255);
        check("mrst_valid", a_valid, 0);
        check("mrst_fcnt", frame_cnt, 0);
        check("mrst_fmax", frame_max, 0);
        check("mrst_upd", a_update, 0);
        tick(1);
        rst_n = 1'b1;
        pixels("f9b", 10, 8'd240, 8'd255);
        end_frame("f9", 1'b0, 8'd255, 0, 8'd0, 1'b0);

        start_frame(1'b0, 8'd0);
        pixels("f10", 64, 8'd200, 8'd255);
        end_frame("f10", 1'b1, 8'd200, 1, 8'd200, 1'b1);

        // Vsync rises one cycle after fall (state CALC): update completes, frame skipped.
        start_frame(1'b0, 8'd0);
        pixels("f11", 30, 8'd120, 8'd200);
        dif.dark_vsync = 1'b0;
        tick(1);
        check("f11_frame_cnt", frame_cnt, 2);
        check("f11_upd_k", a_update, 0);
        dif.dark_vsync = 1'b1;
        tick(1);
        check("f11_upd_k1", a_update, 0);
        tick(1);
        check("f11_upd_k2", a_update, 1);
        check("f11_A", A_value, 180);
        tick(1);
        check("f11_upd_off", a_update, 0);
        pixels("skip", 20, 8'd250, 8'd180);
        end_frame("skip", 1'b0, 8'd180, 2, 8'd120, 1'b1);

        // 180 + (-60 >>> 2) = 165.
        start_frame(1'b0, 8'd0);
        pixels("f12", 30, 8'd120, 8'd180);
        end_frame("f12", 1'b1, 8'd165, 3, 8'd120, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
